// File: rtl/max_scan_ctrl.sv
// max_scan_ctrl: windowed max/argmax over 8-lane beats with a valid/ready result port.
module max_scan_ctrl #(
  parameter int DW    = 8,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*DW-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_max,
  output logic [LEN_W+2:0]  out_idx,
  output logic              busy
);
  // Encoded so that busy and out_valid are direct state flop bits.
  typedef enum logic [1:0] {IDLE = 2'b00, ACC = 2'b01, DONE = 2'b11} state_t;
  state_t state_q, state_d;
  logic [LEN_W:0]   len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [DW-1:0]    max_q, max_d;
  logic [LEN_W+2:0] idx_q, idx_d;
  logic [DW-1:0]    l1_v [4];
  logic [2:0]       l1_i [4];
  logic [DW-1:0]    l2_v [2];
  logic [2:0]       l2_i [2];
  logic [DW-1:0]    beat_max;
  logic [2:0]       beat_lane;
  logic             accept;
  // Strict > at every node lets the higher lane win ties.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      l1_v[i] = in_data[DW*2*i +: DW] > in_data[DW*(2*i+1) +: DW] ? in_data[DW*2*i +: DW] : in_data[DW*(2*i+1) +: DW];
      l1_i[i] = in_data[DW*2*i +: DW] > in_data[DW*(2*i+1) +: DW] ? 3'(2*i) : 3'(2*i+1);
    end
    for (int i = 0; i < 2; i++) begin
      l2_v[i] = l1_v[2*i] > l1_v[2*i+1] ? l1_v[2*i] : l1_v[2*i+1];
      l2_i[i] = l1_v[2*i] > l1_v[2*i+1] ? l1_i[2*i] : l1_i[2*i+1];
    end
    beat_max  = l2_v[0] > l2_v[1] ? l2_v[0] : l2_v[1];
    beat_lane = l2_v[0] > l2_v[1] ? l2_i[0] : l2_i[1];
  end
  assign in_ready  = !reset && !state_q[1];
  assign out_valid = state_q[1];
  assign busy      = state_q[0];
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign accept    = in_valid && !state_q[1];
  assign cnt_inc   = cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    if (accept && state_q == IDLE) begin
      len_d   = cfg_len == '0 ? {1'b1, LEN_W'(0)} : {1'b0, cfg_len};
      max_d   = beat_max;
      idx_d   = {LEN_W'(0), beat_lane};
      cnt_d   = (LEN_W+1)'(1);
      state_d = cfg_len == LEN_W'(1) ? DONE : ACC;
    end else if (accept) begin
      max_d   = beat_max >= max_q ? beat_max : max_q;
      idx_d   = beat_max >= max_q ? {cnt_q[LEN_W-1:0], beat_lane} : idx_q;
      cnt_d   = cnt_inc;
      state_d = cnt_inc == len_q ? DONE : ACC;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_max_scan_ctrl.sv
// tb_max_scan_ctrl: directed vectors with hand-computed max/argmax results.
module tb_max_scan_ctrl;
  logic        clk = 0, reset = 1;
  logic [7:0]  cfg_len = 0;
  logic        in_valid = 0, out_ready = 0;
  logic [63:0] in_data = 0;
  logic        in_ready, out_valid, busy;
  logic [7:0]  out_max;
  logic [10:0] out_idx;
  int n_chk = 0, n_fail = 0;
  max_scan_ctrl dut (
    .clk(clk), .reset(reset), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_idx(out_idx), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [63:0] d);
    in_valid = 1;
    in_data  = d;
    tick();
    in_valid = 0;
  endtask
  task automatic handshake();
    out_ready = 1;
    tick();
    out_ready = 0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_ready", in_ready, 1);
    check("post_hs_busy", busy, 0);
  endtask
  initial begin
    int acc;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_max", out_max, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_busy", busy, 0);
    tick();
    reset = 0;
    #1;
    check("idle_in_ready", in_ready, 1);
    // len=1, tie between lanes 1 and 3 resolves to lane 3
    cfg_len = 1;
    beat(64'h05_07_02_00_09_01_09_03);
    check("l1_valid", out_valid, 1);
    check("l1_max", out_max, 8'h09);
    check("l1_idx", out_idx, 3);
    check("l1_in_ready", in_ready, 0);
    check("l1_busy", busy, 1);
    handshake();
    // len=4 with gaps, unique max C8 at beat 2 lane 5
    cfg_len = 4;
    beat(64'h11_22_33_44_55_66_77_88);
    check("l4_busy0", busy, 1);
    tick();
    check("l4_gap_busy", busy, 1);
    check("l4_gap_valid", out_valid, 0);
    beat(64'hA0_10_20_30_40_50_60_70);
    tick();
    beat(64'h01_02_C8_03_04_05_06_07);
    tick();
    check("l4_gap_valid2", out_valid, 0);
    beat(64'hC7_00_00_00_00_00_00_00);
    check("l4_valid", out_valid, 1);
    check("l4_max", out_max, 8'hC8);
    check("l4_idx", out_idx, 21);
    check("l4_busy", busy, 1);
    handshake();
    // len=3, all equal: last beat, highest lane
    cfg_len = 3;
    for (int i = 0; i < 3; i++) beat({8{8'h40}});
    check("l3_valid", out_valid, 1);
    check("l3_max", out_max, 8'h40);
    check("l3_idx", out_idx, 23);
    handshake();
    // len=2 with backpressure
    cfg_len = 2;
    beat(64'h10);
    beat(64'h20);
    in_valid = 1;
    in_data  = {8{8'hFF}};
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_max", out_max, 8'h20);
      check("bp_idx", out_idx, 8);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 0;
    handshake();
    cfg_len = 1;
    beat(64'h00_00_00_00_00_05_00_00);
    check("next_max", out_max, 8'h05);
    check("next_idx", out_idx, 2);
    handshake();
    // reset mid-window discards the partial result
    cfg_len = 4;
    beat({8{8'hFF}});
    beat({8{8'hFF}});
    reset = 1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_max", out_max, 0);
    check("mid_rst_idx", out_idx, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    tick();
    reset = 0;
    #1;
    cfg_len = 2;
    beat({8{8'h10}});
    beat(64'h00_00_00_00_00_00_00_7F);
    check("post_rst_max", out_max, 8'h7F);
    check("post_rst_idx", out_idx, 8);
    handshake();
    // 256-beat window; cfg_len change mid-window is ignored
    cfg_len = 0;
    in_valid = 1;
    acc = 0;
    for (int i = 0; i < 300 && !out_valid; i++) begin
      in_data = acc == 255 ? 64'hFF00_0000_0000_0000 : 64'h0;
      if (in_ready) acc++;
      tick();
      cfg_len = 5;
    end
    in_valid = 0;
    check("w256_valid", out_valid, 1);
    check("w256_beats", acc, 256);
    check("w256_max", out_max, 8'hFF);
    check("w256_idx", out_idx, 2047);
    handshake();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
